// File: rtl/alu_exec_seq.sv
// Execute-stage ALU with valid/ready handshakes: logic/arith ops finish in one
// cycle, shifts iterate one bit per cycle through a small shift register.
module alu_exec_seq #(
   parameter int N_BITS       = 32,
   parameter int N_BITS_CTRL  = 5,
   parameter int N_BITS_SHAMT = 5
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [N_BITS_CTRL-1:0]  i_alu_ctrl,
   input  logic [N_BITS-1:0]       i_dato_a,
   input  logic [N_BITS-1:0]       i_dato_b,
   input  logic [N_BITS_SHAMT-1:0] i_shamt,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [N_BITS-1:0]       o_resultado,
   output logic                    o_zero,
   output logic                    o_overflow,
   output logic                    o_invalid
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

   state_t                  state, state_next;
   shift_t                  sh_kind, dec_kind;
   logic [N_BITS-1:0]       sreg, sreg_step;
   logic [N_BITS_SHAMT-1:0] cnt, dec_amt;
   logic [N_BITS-1:0]       sum, diff, alu_res;
   logic                    alu_ovf, alu_inv, is_shift;

   assign sum  = i_dato_a + i_dato_b;
   assign diff = i_dato_a - i_dato_b;

   // NOTE: every variable gets a default before the case, so no latch is inferred.
   always_comb begin
      alu_res  = '0;
      alu_ovf  = 1'b0;
      alu_inv  = 1'b0;
      is_shift = 1'b0;
      dec_kind = SH_LL;
      dec_amt  = i_shamt;
      case (i_alu_ctrl)
         5'b00000: alu_res = i_dato_a & i_dato_b;
         5'b00001: alu_res = i_dato_a | i_dato_b;
         5'b00010: begin
            alu_res = sum;
            alu_ovf = (i_dato_a[N_BITS-1] == i_dato_b[N_BITS-1]) &&
                      (sum[N_BITS-1] != i_dato_a[N_BITS-1]);
         end
         5'b00011: alu_res = sum;
         5'b00100: alu_res = ~(i_dato_a | i_dato_b);
         5'b00101: alu_res = i_dato_a ^ i_dato_b;
         5'b00111: begin
            alu_res = diff;
            alu_ovf = (i_dato_a[N_BITS-1] != i_dato_b[N_BITS-1]) &&
                      (diff[N_BITS-1] != i_dato_a[N_BITS-1]);
         end
         5'b01000: alu_res = diff;
         5'b01001: alu_res = {{(N_BITS-1){1'b0}}, $signed(i_dato_a) < $signed(i_dato_b)};
         5'b01100: alu_res = {i_dato_b[15:0], {(N_BITS-16){1'b0}}};
         5'b01101, 5'b01110, 5'b01111, 5'b10000: alu_res = sum;
         5'b00110: is_shift = 1'b1;
         5'b01010: begin is_shift = 1'b1; dec_kind = SH_RL; end
         5'b01011: begin is_shift = 1'b1; dec_kind = SH_RA; end
         // Variable shifts take the amount from the low bits of operand A.
         5'b10010: begin is_shift = 1'b1; dec_amt = i_dato_a[N_BITS_SHAMT-1:0]; end
         5'b10011: begin is_shift = 1'b1; dec_kind = SH_RL; dec_amt = i_dato_a[N_BITS_SHAMT-1:0]; end
         5'b10001: begin is_shift = 1'b1; dec_kind = SH_RA; dec_amt = i_dato_a[N_BITS_SHAMT-1:0]; end
         default:  alu_inv = 1'b1;
      endcase
   end

   always_comb begin
      case (sh_kind)
         SH_LL:   sreg_step = {sreg[N_BITS-2:0], 1'b0};
         SH_RL:   sreg_step = {1'b0, sreg[N_BITS-1:1]};
         default: sreg_step = {sreg[N_BITS-1], sreg[N_BITS-1:1]};
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      o_ready    = 1'b0;
      o_valid    = 1'b0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) state_next = (is_shift && dec_amt != '0) ? SHIFT : DONE;
         end
         SHIFT: if (cnt == N_BITS_SHAMT'(1)) state_next = DONE;
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Result and flags only move on accept or shift completion, so they hold through DONE.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sreg        <= '0;
         cnt         <= '0;
         sh_kind     <= SH_LL;
         o_resultado <= '0;
         o_zero      <= 1'b0;
         o_overflow  <= 1'b0;
         o_invalid   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_valid) begin
               if (is_shift) begin
                  sreg    <= i_dato_b;
                  cnt     <= dec_amt;
                  sh_kind <= dec_kind;
                  if (dec_amt == '0) begin
                     o_resultado <= i_dato_b;
                     o_zero      <= (i_dato_b == '0);
                     o_overflow  <= 1'b0;
                     o_invalid   <= 1'b0;
                  end
               end else begin
                  o_resultado <= alu_res;
                  o_zero      <= (alu_res == '0);
                  o_overflow  <= alu_ovf;
                  o_invalid   <= alu_inv;
               end
            end
            SHIFT: begin
               sreg <= sreg_step;
               cnt  <= cnt - 1'b1;
               if (cnt == N_BITS_SHAMT'(1)) begin
                  o_resultado <= sreg_step;
                  o_zero      <= (sreg_step == '0);
                  o_overflow  <= 1'b0;
                  o_invalid   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed-vector bench for alu_exec_seq: reset, arithmetic/logic codes,
// iterative shift latency, backpressure and reset during a shift.
module tb_alu_exec_seq;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [4:0]  i_alu_ctrl = '0;
   logic [31:0] i_dato_a = '0;
   logic [31:0] i_dato_b = '0;
   logic [4:0]  i_shamt = '0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [31:0] o_resultado;
   logic        o_zero, o_overflow, o_invalid;

   int n_vec = 0;
   int n_err = 0;

   alu_exec_seq dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_alu_ctrl(i_alu_ctrl), .i_dato_a(i_dato_a), .i_dato_b(i_dato_b),
      .i_shamt(i_shamt), .o_valid(o_valid), .i_ready(i_ready),
      .o_resultado(o_resultado), .o_zero(o_zero), .o_overflow(o_overflow),
      .o_invalid(o_invalid)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge with the DUT idle; returns the same way, idle again.
   task automatic do_op(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] shamt, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_z, input logic exp_ov,
                        input logic exp_inv, input int hold);
      int lat;
      logic rdy_bad, bp_bad;
      rdy_bad = 1'b0;
      bp_bad  = 1'b0;
      i_alu_ctrl = ctrl; i_dato_a = a; i_dato_b = b; i_shamt = shamt;
      i_valid = 1'b1;
      i_ready = (hold == 0);
      check({tag, " ready_at_accept"}, 32'(o_ready), 32'd1);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 64) begin
         if (o_ready) rdy_bad = 1'b1;
         @(posedge i_clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " ready_low_while_busy"}, 32'(rdy_bad | o_ready), 32'd0);
      check({tag, " result"}, o_resultado, exp_res);
      check({tag, " flags_z_ov_inv"}, {29'd0, o_zero, o_overflow, o_invalid},
            {29'd0, exp_z, exp_ov, exp_inv});
      for (int i = 0; i < hold; i++) begin
         i_valid = 1'b1;
         i_alu_ctrl = 5'b00011; i_dato_a = 32'h1111_1111; i_dato_b = 32'h2222_2222;
         @(posedge i_clk); #1;
         if (!o_valid || o_ready || o_resultado !== exp_res ||
             {o_zero, o_overflow, o_invalid} !== {exp_z, exp_ov, exp_inv})
            bp_bad = 1'b1;
      end
      if (hold > 0) check({tag, " stable_under_backpressure"}, 32'(bp_bad), 32'd0);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      check({tag, " valid_drops_after_handshake"}, 32'(o_valid), 32'd0);
      check({tag, " ready_after_handshake"}, 32'(o_ready), 32'd1);
   endtask

   initial begin
      logic seen_valid;
      // Reset asserted mid-cycle: outputs clear immediately.
      #3 i_reset = 1'b1;
      #1;
      check("reset_ready", 32'(o_ready), 32'd1);
      check("reset_outputs", {o_resultado}, 32'd0);
      check("reset_flags_valid", {28'd0, o_valid, o_zero, o_overflow, o_invalid}, 32'd0);
      @(posedge i_clk); @(posedge i_clk); #1;
      i_reset = 1'b0;

      do_op("add_7_5",     5'b00010, 32'd7,          32'd5, 5'd0, 1, 32'd12,         0, 0, 0, 0);
      do_op("add_ovf",     5'b00010, 32'h7FFF_FFFF,  32'd1, 5'd0, 1, 32'h8000_0000,  0, 1, 0, 0);
      do_op("addu_wrap",   5'b00011, 32'h7FFF_FFFF,  32'd1, 5'd0, 1, 32'h8000_0000,  0, 0, 0, 0);
      do_op("sub_zero",    5'b00111, 32'd5,          32'd5, 5'd0, 1, 32'd0,          1, 0, 0, 0);
      do_op("sub_ovf",     5'b00111, 32'h8000_0000,  32'd1, 5'd0, 1, 32'h7FFF_FFFF,  0, 1, 0, 0);
      do_op("subu",        5'b01000, 32'd3,          32'd5, 5'd0, 1, 32'hFFFF_FFFE,  0, 0, 0, 0);
      do_op("nor",         5'b00100, 32'd0,          32'd0, 5'd0, 1, 32'hFFFF_FFFF,  0, 0, 0, 0);
      do_op("xor",         5'b00101, 32'hFF00_FF00,  32'h0FF0_0FF0, 5'd0, 1, 32'hF0F0_F0F0, 0, 0, 0, 0);
      do_op("or",          5'b00001, 32'h0000_00F0,  32'h0000_000F, 5'd0, 1, 32'h0000_00FF, 0, 0, 0, 0);
      do_op("ld_addr_novf",5'b01101, 32'h7FFF_FFFF,  32'd1, 5'd0, 1, 32'h8000_0000,  0, 0, 0, 0);
      do_op("sra_4",       5'b01011, 32'd0,          32'h8000_0000, 5'd4, 5, 32'hF800_0000, 0, 0, 0, 0);
      do_op("sllv_31",     5'b10010, 32'd31,         32'd1, 5'd0, 32, 32'h8000_0000, 0, 0, 0, 0);
      do_op("sll_0",       5'b00110, 32'd0,          32'hDEAD_BEEF, 5'd0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
      do_op("srlv_4",      5'b10011, 32'd4,          32'h8000_0000, 5'd9, 5, 32'h0800_0000, 0, 0, 0, 0);
      do_op("srav_a_low",  5'b10001, 32'h0000_0024,  32'h8000_0000, 5'd0, 5, 32'hF800_0000, 0, 0, 0, 0);
      do_op("srl_out_zero",5'b01010, 32'd0,          32'h0000_0003, 5'd2, 3, 32'd0,          1, 0, 0, 0);
      do_op("and_bp",      5'b00000, 32'hF0F0_F0F0,  32'hFF00_FF00, 5'd0, 1, 32'hF000_F000, 0, 0, 0, 6);
      do_op("slt_neg",     5'b01001, 32'hFFFF_FFFF,  32'd1, 5'd0, 1, 32'd1,          0, 0, 0, 0);
      do_op("lui",         5'b01100, 32'd0,          32'h0000_1234, 5'd0, 1, 32'h1234_0000, 0, 0, 0, 0);
      do_op("invalid",     5'b10100, 32'd9,          32'd9, 5'd0, 1, 32'd0,          1, 0, 1, 0);

      // Reset during a 20-step srl: the operation must vanish without o_valid.
      i_alu_ctrl = 5'b01010; i_dato_b = 32'hFFFF_FFFF; i_shamt = 5'd20; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      seen_valid = 1'b0;
      repeat (7) begin
         seen_valid |= o_valid;
         @(posedge i_clk); #1;
      end
      #2 i_reset = 1'b1;
      #1;
      check("midshift_reset_ready", 32'(o_ready), 32'd1);
      check("midshift_reset_result", o_resultado, 32'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      repeat (25) begin
         seen_valid |= o_valid;
         @(posedge i_clk); #1;
      end
      check("midshift_no_valid", 32'(seen_valid), 32'd0);
      do_op("add_after_rst", 5'b00010, 32'd100, 32'hFFFF_FFFF, 5'd0, 1, 32'd99, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Execute-stage ALU that consumes the 5-bit ALU control code produced by the pipeline's ALU control decoder.
- Operands are A and B. The result is registered and returned through valid/ready handshakes.
- Logic and arithmetic ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, so the shifter stays small.
- Sits between the ID/EX register and the EX/MEM register; the hazard unit stalls on o_ready low.

Parameters:
- N_BITS, 32, operand/result width
- N_BITS_CTRL, 5, ALU control code width
- N_BITS_SHAMT, 5, shift amount width (log2 N_BITS)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  operation request
- o_ready  out  1  block can accept a request
- i_alu_ctrl  in  N_BITS_CTRL  operation code
- i_dato_a  in  N_BITS  operand A (rs); A[4:0] is the shift amount for variable shifts
- i_dato_b  in  N_BITS  operand B (rt/immediate); value shifted by shifts
- i_shamt  in  N_BITS_SHAMT  shift amount for fixed shifts
- o_valid  out  1  result available
- i_ready  in  1  downstream accepts result
- o_resultado  out  N_BITS  result
- o_zero  out  1  result == 0
- o_overflow  out  1  signed overflow (0x02 add, 0x07 sub only)
- o_invalid  out  1  unrecognised code

Behaviour:
- Reset: clock is i_clk; reset is i_reset, asynchronous and active-high.
  - While reset is asserted: state IDLE, o_ready=1, o_valid=0, o_resultado=0, o_zero=0, o_overflow=0, o_invalid=0, counter=0.
  - Reset mid-operation aborts the operation; nothing is reported.
- Code table (output registered; add/sub wrap mod 2^N_BITS):
  - 00000 and; 00001 or; 00010 add (signed); 00011 addu; 00100 nor; 00101 xor.
  - 00111 sub (signed, A-B); 01000 subu.
  - 01001 slt: 1 if signed A<B, else 0.
  - 01100 lui: {B[15:0],16'h0}.
  - 01101, 01110, 01111, 10000 (load address calc): A+B, no overflow.
  - 00110 sll, 01010 srl, 01011 sra: shift B by i_shamt.
  - 10010 sllv, 10011 srlv, 10001 srav: shift B by A[4:0].
  - Any other code: o_resultado=0, o_invalid=1, o_zero=1.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1. Accept on i_valid&&o_ready; operands and code are captured at that edge.
  - Non-shift op: result and flags latched, go to DONE, so o_valid=1 the cycle after accept.
  - Shift op: load shift register=B and count=amount.
    - count==0: result=B, go to DONE directly.
    - Otherwise go to SHIFT.
- SHIFT:
  - o_ready=0.
  - Each cycle, shift by one bit: sll fills 0 on the right; srl fills 0 on the left; sra replicates the MSB. Then count-=1.
  - When count reaches 0, latch the result and go to DONE.
  - Latency from accept to o_valid = 1+amount cycles (amount 31 -> 32 cycles).
- DONE:
  - o_valid=1, o_ready=0. Result and flags are held stable until i_ready.
  - o_valid&&i_ready: go to IDLE; o_valid drops next cycle.
  - A new request can be accepted at the earliest one cycle after the handshake.
  - Maximum throughput is one op per 2 cycles.
- Flags:
  - o_zero is computed from the final result.
  - o_overflow=0 for all codes other than 00010 and 00111.
  - o_overflow, o_zero and o_invalid are valid only while o_valid=1; they retain their last value otherwise.
- i_valid outside IDLE is ignored; the requester must hold it until o_ready.
- Output changes occur only on clock edges, except under asynchronous reset.

Test Plan:
- Reset and single-cycle add:
  - Assert i_reset mid-cycle -> all outputs 0 and o_ready=1 immediately.
  - Release; code 00010, A=7, B=5, i_ready=1 -> o_valid one cycle after accept, o_resultado=12, o_zero=0, o_overflow=0.
- Signed overflow and wrap:
  - Code 00010, A=0x7FFFFFFF, B=1 -> o_resultado=0x80000000, o_overflow=1.
  - Code 00011, same operands -> same result, o_overflow=0.
  - Code 00111, A=5, B=5 -> o_resultado=0, o_zero=1.
- Iterative shifts:
  - Code 01011 (sra), B=0x80000000, i_shamt=4 -> o_valid exactly 5 cycles after accept, o_resultado=0xF8000000, o_ready=0 throughout.
  - Code 10010 (sllv), A=31, B=1 -> 0x80000000 after 32 cycles.
  - Shift amount 0 -> result B after 1 cycle.
- Backpressure:
  - i_ready=0 for 6 cycles after o_valid -> o_resultado and flags stable, o_ready=0, new i_valid ignored.
  - Raise i_ready -> o_valid low next cycle, next request accepted the cycle after.
- Misc codes:
  - slt, A=-1, B=1 -> result 1.
  - lui, B=0x00001234 -> 0x12340000.
  - Code 10100 -> o_resultado=0, o_invalid=1, o_zero=1.
- Reset mid-shift:
  - srl with amount 20; assert i_reset at cycle 8 -> state IDLE, o_valid never asserted for that op.
  - After release, a new add completes normally.
